gate_bist_sequencer: RTL and testbench

//  Built-in self-test sequencer for a 2-input combinational gate cell (default: NAND).

---
 rtl/gate_bist_sequencer_if.sv | 38 +++
 rtl/gate_bist_sequencer.sv | 94 +++++++++
 tb/tb_gate_bist_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/gate_bist_sequencer_if.sv
// Stimulus/response bundle between the gate BIST sequencer and the cell under test.
// The master side is the sequencer; the slave side is the gate cell plus whoever
// requests a test and reads the result.
interface gate_bist_sequencer_if;
    logic       start;
    logic       A;
    logic       B;
    logic       Y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] captured;
    logic [3:0] fail_mask;

    modport master (
        input  start,
        input  Y,
        output A,
        output B,
        output busy,
        output done,
        output pass,
        output captured,
        output fail_mask
    );

    modport slave (
        output start,
        output Y,
        input  A,
        input  B,
        input  busy,
        input  done,
        input  pass,
        input  captured,
        input  fail_mask
    );
endinterface

// File: rtl/gate_bist_sequencer.sv
// Built-in self-test sequencer for a 2-input combinational gate cell.
// It walks {A,B} through 00,01,10,11, holds each vector for SETTLE_CYCLES cycles,
// samples Y one cycle later and compares the captured truth table with EXPECTED.
// Results (captured, fail_mask, pass) stay valid until the next accepted start.
module gate_bist_sequencer #(
    parameter logic [3:0] EXPECTED      = 4'b0111,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    gate_bist_sequencer_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

    // A settle time of 0 would sample Y in the cycle A/B change, and the counter is only 4 bits.
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("gate_bist_sequencer: SETTLE_CYCLES must be in 1..15");
    end

    state_t     state;
    logic [1:0] idx;
    logic [3:0] cnt;

    // Single sequencer FSM; every output is a register so the gate under test sees clean stimulus.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= 2'd0;
            cnt           <= 4'd0;
            bus.A         <= 1'b0;
            bus.B         <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.captured  <= 4'd0;
            bus.fail_mask <= 4'd0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    bus.A <= 1'b0;
                    bus.B <= 1'b0;
                    if (bus.start) begin
                        state         <= APPLY;
                        idx           <= 2'd0;
                        cnt           <= 4'd0;
                        bus.busy      <= 1'b1;
                        bus.pass      <= 1'b0;
                        bus.captured  <= 4'd0;
                        bus.fail_mask <= 4'd0;
                    end
                end
                APPLY: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_CNT) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    bus.captured[idx]  <= bus.Y;
                    bus.fail_mask[idx] <= bus.Y ^ EXPECTED[idx];
                    if (idx == 2'd3) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                    end else begin
                        idx            <= idx + 2'd1;
                        cnt            <= 4'd0;
                        {bus.A, bus.B} <= idx + 2'd1;
                        state          <= APPLY;
                    end
                end
                DONE: begin
                    bus.done <= 1'b1;
                    bus.pass <= ~|bus.fail_mask;
                    bus.A    <= 1'b0;
                    bus.B    <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist_sequencer.sv
// Self-checking bench for gate_bist_sequencer: one instance with default settling,
// one with SETTLE_CYCLES=1, both driven by a programmable truth-table "gate".
module tb_gate_bist_sequencer;

    localparam logic [3:0] EXP = 4'b0111;

    typedef struct {
        int         sel;
        logic [3:0] lut;
        logic [3:0] cap;
        logic [3:0] fmask;
        logic       pass_v;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [3:0] gate_lut;
    int         tests;
    int         failures;
    vec_t       vecs[6];

    gate_bist_sequencer_if bus0();
    gate_bist_sequencer_if bus1();

    assign bus0.Y = gate_lut[{bus0.A, bus0.B}];
    assign bus1.Y = gate_lut[{bus1.A, bus1.B}];

    gate_bist_sequencer #(.EXPECTED(EXP), .SETTLE_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0.master)
    );

    gate_bist_sequencer #(.EXPECTED(EXP), .SETTLE_CYCLES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.master)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison
    task automatic checkOutput(input string name, input int cyc, input logic [3:0] act, input logic [3:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            failures++;
            $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp_v);
        end
    endtask

    task automatic driveStart(input int sel, input logic v);
        if (sel == 1) bus1.start = v;
        else          bus0.start = v;
    endtask

    // Reference: what the outputs should be after edge ph of a run, with edge 0 the accepted start.
    // Each vector owns (s+1) edges; done follows the vector walk by one edge.
    function automatic void refCycle(input int s, input int ph, input logic [3:0] lut,
                                     output logic [1:0] ab, output logic busy_e, output logic done_e,
                                     output logic [3:0] cap, output logic [3:0] fmask, output logic pass_e);
        int hold;
        int done_edge;
        int v;
        hold      = s + 1;
        done_edge = 4 * hold + 1;
        v         = ph / hold;
        if (v > 3) v = 3;
        ab     = (ph >= done_edge) ? 2'd0 : 2'(v);
        busy_e = (ph < 4 * hold);
        done_e = (ph == done_edge);
        cap    = 4'd0;
        fmask  = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (ph >= (i + 1) * hold) begin
                cap[i]   = lut[i];
                fmask[i] = lut[i] ^ EXP[i];
            end
        end
        pass_e = (ph >= done_edge) ? (fmask == 4'd0) : 1'b0;
    endfunction

    // Launch nruns back-to-back runs, check every cycle against the model, then the final results.
    task automatic applyStimulus(input string name, input int sel, input logic [3:0] lut,
                                 input int nruns, input int hold_edges, input int pulse1, input int pulse2,
                                 input logic [3:0] exp_cap, input logic [3:0] exp_fail, input logic exp_pass);
        int s;
        int period;
        int last;
        int ph;
        logic [1:0] e_ab;
        logic e_busy, e_done, e_pass;
        logic [3:0] e_cap, e_fmask;
        logic [1:0] a_ab;
        logic a_busy, a_done, a_pass;
        logic [3:0] a_cap, a_fmask;
        s      = (sel == 1) ? 1 : 2;
        period = 4 * (s + 1) + 2;
        last   = nruns * period + 1;
        gate_lut = lut;
        @(negedge clk);
        driveStart(sel, 1'b1);
        for (int k = 0; k <= last; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k >= nruns * period) begin
                refCycle(s, period - 1, lut, e_ab, e_busy, e_done, e_cap, e_fmask, e_pass);
                e_done = 1'b0;
            end else begin
                ph = k % period;
                refCycle(s, ph, lut, e_ab, e_busy, e_done, e_cap, e_fmask, e_pass);
            end
            if (sel == 1) begin
                a_ab = {bus1.A, bus1.B}; a_busy = bus1.busy; a_done = bus1.done;
                a_pass = bus1.pass; a_cap = bus1.captured; a_fmask = bus1.fail_mask;
            end else begin
                a_ab = {bus0.A, bus0.B}; a_busy = bus0.busy; a_done = bus0.done;
                a_pass = bus0.pass; a_cap = bus0.captured; a_fmask = bus0.fail_mask;
            end
            checkOutput({name, "_ab"},       k, {2'b00, a_ab},  {2'b00, e_ab});
            checkOutput({name, "_busy"},     k, {3'b000, a_busy}, {3'b000, e_busy});
            checkOutput({name, "_done"},     k, {3'b000, a_done}, {3'b000, e_done});
            checkOutput({name, "_pass"},     k, {3'b000, a_pass}, {3'b000, e_pass});
            checkOutput({name, "_captured"}, k, a_cap,   e_cap);
            checkOutput({name, "_failmask"}, k, a_fmask, e_fmask);
            driveStart(sel, (k + 1 < hold_edges) || (k + 1 == pulse1) || (k + 1 == pulse2));
        end
        driveStart(sel, 1'b0);
        checkOutput({name, "_final_captured"}, last, a_cap, exp_cap);
        checkOutput({name, "_final_failmask"}, last, a_fmask, exp_fail);
        checkOutput({name, "_final_pass"},     last, {3'b000, a_pass}, {3'b000, exp_pass});
    endtask

    initial begin
        logic [3:0] rlut;
        tests      = 0;
        failures   = 0;
        gate_lut   = 4'b0111;
        bus0.start = 1'b0;
        bus1.start = 1'b0;

        // sel, gate truth table, expected captured, fail_mask, pass
        vecs[0] = '{0, 4'b0111, 4'b0111, 4'b0000, 1'b1};
        vecs[1] = '{0, 4'b1000, 4'b1000, 4'b1111, 1'b0};
        vecs[2] = '{0, 4'b1111, 4'b1111, 4'b1000, 1'b0};
        vecs[3] = '{0, 4'b0000, 4'b0000, 4'b0111, 1'b0};
        vecs[4] = '{0, 4'b0110, 4'b0110, 4'b0001, 1'b0};
        vecs[5] = '{1, 4'b0111, 4'b0111, 4'b0000, 1'b1};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ab",       0, {2'b00, bus0.A, bus0.B}, 4'd0);
        checkOutput("reset_busy",     0, {3'b000, bus0.busy}, 4'd0);
        checkOutput("reset_done",     0, {3'b000, bus0.done}, 4'd0);
        checkOutput("reset_pass",     0, {3'b000, bus0.pass}, 4'd0);
        checkOutput("reset_captured", 0, bus0.captured, 4'd0);
        checkOutput("reset_failmask", 0, bus0.fail_mask, 4'd0);
        checkOutput("reset1_busy",    0, {3'b000, bus1.busy}, 4'd0);
        checkOutput("reset1_pass",    0, {3'b000, bus1.pass}, 4'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus($sformatf("tbl%0d", i), vecs[i].sel, vecs[i].lut, 1, 1, -1, -1,
                          vecs[i].cap, vecs[i].fmask, vecs[i].pass_v);
        end

        // Start re-pulsed mid-run and during DONE must be ignored, then a fresh run passes
        applyStimulus("repulse", 0, 4'b0111, 1, 1, 3, 13, 4'b0111, 4'b0000, 1'b1);
        applyStimulus("after_repulse", 0, 4'b0111, 1, 1, -1, -1, 4'b0111, 4'b0000, 1'b1);

        // Start held high: two runs separated by one IDLE cycle
        applyStimulus("held_start", 0, 4'b0111, 2, 15, -1, -1, 4'b0111, 4'b0000, 1'b1);

        // Reset while the third vector (idx 2) is applied
        gate_lut = 4'b0111;
        @(negedge clk);
        bus0.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_pre_ab",  6, {2'b00, bus0.A, bus0.B}, 4'b0010);
        checkOutput("midrst_pre_cap", 6, bus0.captured, 4'b0011);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_ab",       7, {2'b00, bus0.A, bus0.B}, 4'd0);
        checkOutput("midrst_busy",     7, {3'b000, bus0.busy}, 4'd0);
        checkOutput("midrst_done",     7, {3'b000, bus0.done}, 4'd0);
        checkOutput("midrst_pass",     7, {3'b000, bus0.pass}, 4'd0);
        checkOutput("midrst_captured", 7, bus0.captured, 4'd0);
        checkOutput("midrst_failmask", 7, bus0.fail_mask, 4'd0);
        for (int k = 8; k < 20; k++) begin
            @(negedge clk);
            checkOutput("midrst_no_done", k, {3'b000, bus0.done}, 4'd0);
            checkOutput("midrst_no_busy", k, {3'b000, bus0.busy}, 4'd0);
        end
        applyStimulus("after_midrst", 0, 4'b0111, 1, 1, -1, -1, 4'b0111, 4'b0000, 1'b1);

        // Random truth tables on both settle settings
        for (int r = 0; r < 12; r++) begin
            rlut = 4'($urandom_range(0, 15));
            applyStimulus($sformatf("rand%0d", r), r % 2, rlut, 1, 1, -1, -1,
                          rlut, rlut ^ EXP, ((rlut ^ EXP) == 4'd0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
